uart_tx_arbiter: RTL and testbench

// Shares one UART_TX transmitter among NREQ byte requesters. Round-robin

---
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters,
// with burst locking, lock timeout and a programmable inter-frame idle gap.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int N        = 8,
  parameter int GAP      = 8,
  parameter int LOCK_TMO = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              tx_start,
  output logic [N-1:0]      tx_data,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          r_state, w_state_next;
  logic [PW-1:0]   r_ptr, w_ptr_next;
  logic            r_lock, w_lock_next;
  logic [NREQ-1:0] r_grant, w_grant_next;
  logic [NREQ-1:0] r_req_ready, w_req_ready_next;
  logic            r_tx_start, w_tx_start_next;
  logic [N-1:0]    r_tx_data, w_tx_data_next;
  logic            r_busy, w_busy_next;
  logic            r_issued, w_issued_next;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_next;
  logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_next;
  logic            w_tmo_fire;

  logic [NREQ-1:0] w_owner_oh;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_cand;
  logic [PW-1:0]   w_winner;
  logic            w_found;
  logic            w_own_valid;
  logic            w_own_last;
  logic [N-1:0]    w_own_data;
  int              w_idx;

  // r_ptr always names the current (or most recent) owner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign w_owner_oh[gi] = (r_ptr == PW'(gi));
    assign w_win_oh[gi]   = (w_winner == PW'(gi));
  end

  assign w_cand      = r_lock ? (req_valid & w_owner_oh) : req_valid;
  assign w_own_valid = |(req_valid & w_owner_oh);
  assign w_own_last  = |(req_last & w_owner_oh);

  always_comb begin
    w_own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_owner_oh[i]) w_own_data = req_data[i*N +: N];
    end
  end

  // Scan from ptr+NREQ down to ptr+1 so the nearest candidate after ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (w_cand[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_lock_next      = r_lock;
    w_grant_next     = r_grant;
    w_req_ready_next = '0;
    w_tx_start_next  = 1'b0;
    w_tx_data_next   = r_tx_data;
    w_issued_next    = r_issued;
    w_gap_cnt_next   = r_gap_cnt;
    w_tmo_cnt_next   = r_tmo_cnt;
    w_tmo_fire       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (LOCK_TMO != 0 && r_lock && !w_own_valid) begin
          if (r_tmo_cnt == TW'(LOCK_TMO - 1)) begin
            w_lock_next    = 1'b0;
            w_grant_next   = '0;
            w_tmo_cnt_next = '0;
            w_tmo_fire     = 1'b1;
          end else begin
            w_tmo_cnt_next = r_tmo_cnt + 1'b1;
          end
        end else begin
          w_tmo_cnt_next = '0;
          if (tx_ready && w_found) begin
            w_grant_next = w_win_oh;
            w_ptr_next   = w_winner;
            w_state_next = S_SEND;
          end
        end
      end

      S_SEND: begin
        if (w_own_valid) begin
          w_req_ready_next = w_owner_oh;
          w_tx_data_next   = w_own_data;
          w_lock_next      = ~w_own_last;
          w_issued_next    = 1'b0;
          w_state_next     = S_WAIT_ACK;
        end else begin
          w_grant_next = '0;
          w_state_next = S_IDLE;
        end
      end

      // First cycle here issues the start; afterwards wait for the UART to go busy.
      S_WAIT_ACK: begin
        if (!r_issued) begin
          w_tx_start_next = 1'b1;
          w_issued_next   = 1'b1;
        end else if (!tx_ready) begin
          w_state_next = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (tx_ready) begin
          if (!r_lock) w_grant_next = '0;
          if (GAP > 0) begin
            w_gap_cnt_next = '0;
            w_state_next   = S_GAP;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GW'(GAP - 1)) begin
          w_gap_cnt_next = '0;
          w_state_next   = S_IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Hold busy across the timeout cycle so a waiting requester sees no dip.
    w_busy_next = (w_state_next != S_IDLE) || w_lock_next || w_tmo_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NREQ - 1);
      r_lock      <= 1'b0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b0;
      r_issued    <= 1'b0;
      r_gap_cnt   <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_lock      <= w_lock_next;
      r_grant     <= w_grant_next;
      r_req_ready <= w_req_ready_next;
      r_tx_start  <= w_tx_start_next;
      r_tx_data   <= w_tx_data_next;
      r_busy      <= w_busy_next;
      r_issued    <= w_issued_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
    end
  end

  assign req_ready = r_req_ready;
  assign grant     = r_grant;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester FIFOs, a simple UART_TX timing model,
// table-driven arbitration vectors and hand-written lock/reset/gap sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int N        = 8;
  localparam int GAP      = 8;
  localparam int LOCK_TMO = 40;
  localparam int FRAME    = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_data  = '0;
  logic [NREQ-1:0]   req_last  = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_start;
  logic [N-1:0]      tx_data;
  logic              tx_ready;
  logic              busy;
  logic              hold = 1'b0;
  int                u_cnt = 0;

  // Second instance built with GAP=0 and a permanently requesting client.
  logic [NREQ-1:0]   z_valid = '0;
  logic [NREQ*N-1:0] z_req_data = '0;
  logic [NREQ-1:0]   z_last = '0;
  logic [NREQ-1:0]   z_ready;
  logic [NREQ-1:0]   z_grant;
  logic              z_start;
  logic [N-1:0]      z_data;
  logic              z_tx_ready;
  logic              z_busy;
  int                z_cnt = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] fifo [NREQ][16];
  int         head [NREQ];
  int         tail [NREQ];

  int         obs_idx[$];
  logic [7:0] obs_data[$];
  int         z_starts[$];
  int         multi_grant = 0;
  int         ready_rise_cyc = 0;
  int         grant_rise_cyc = 0;
  int         last_start_cyc = 0;
  logic       prev_ready = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  typedef struct {
    logic        rst_first;
    logic [3:0]  mask;
    logic [31:0] data;
    int          nexp;
    logic [7:0]  exp_idx;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[6];

  uart_tx_arbiter #(.NREQ(NREQ), .N(N), .GAP(GAP), .LOCK_TMO(LOCK_TMO)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
  );

  uart_tx_arbiter #(.NREQ(NREQ), .N(N), .GAP(0), .LOCK_TMO(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_data(z_req_data),
    .req_last(z_last), .req_ready(z_ready), .grant(z_grant),
    .tx_start(z_start), .tx_data(z_data), .tx_ready(z_tx_ready), .busy(z_busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART_TX timing model: accepts a start while idle, then busy FRAME cycles.
  assign tx_ready   = (u_cnt == 0) && !hold;
  assign z_tx_ready = (z_cnt == 0);

  always @(posedge clk) begin
    if (tx_start && tx_ready) u_cnt <= FRAME;
    else if (u_cnt != 0)      u_cnt <= u_cnt - 1;
    if (z_start && z_tx_ready) z_cnt <= FRAME;
    else if (z_cnt != 0)       z_cnt <= z_cnt - 1;
  end

  function automatic int oh2idx(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Monitor and requester driver, sampled 1 time unit after each edge.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        obs_idx.push_back(oh2idx(grant));
        obs_data.push_back(tx_data);
        last_start_cyc = cyc;
      end
      if (z_start) z_starts.push_back(cyc);
      if ($countones(grant) > 1) multi_grant++;
      if (tx_ready && !prev_ready) ready_rise_cyc = cyc;
      prev_ready = tx_ready;
      if (grant != '0 && grant != prev_grant) grant_rise_cyc = cyc;
      prev_grant = grant;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && head[i] != tail[i]) begin
          {req_last[i], req_data[i*N +: N]} = fifo[i][head[i] % 16];
          req_valid[i] = 1'b1;
          head[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    fifo[i][tail[i] % 16] = {l, d};
    tail[i]++;
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    tick();
    tick();
    rst = 1'b0;
    obs_idx.delete();
    obs_data.delete();
  endtask

  task automatic wait_obs(input string name, input int n, input int budget);
    int b;
    b = 0;
    while (obs_idx.size() < n && b < budget) begin
      tick();
      b++;
    end
    if (obs_idx.size() < n) chk({name, "_frame_timeout"}, obs_idx.size(), n);
  endtask

  task automatic wait_idle(input string name);
    int b;
    b = 0;
    while (busy && b < 300) begin
      tick();
      b++;
    end
    if (busy) chk({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic wait_grant(input string name, input logic [NREQ-1:0] want, input int budget);
    int b;
    b = 0;
    while (grant != want && b < budget) begin
      tick();
      b++;
    end
    if (grant != want) chk({name, "_grant_timeout"}, int'(grant), int'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int viol;
    int busy_drop;
    vec_t v;

    vecs[0] = '{1'b1, 4'b1111, 32'h1CFF002B, 4, 8'hE4, 32'h1CFF002B};
    vecs[1] = '{1'b0, 4'b0001, 32'h00000077, 1, 8'h00, 32'h00000077};
    vecs[2] = '{1'b0, 4'b1010, 32'hC300A100, 2, 8'h0D, 32'h0000C3A1};
    vecs[3] = '{1'b0, 4'b0110, 32'h00201000, 2, 8'h09, 32'h00002010};
    vecs[4] = '{1'b0, 4'b1111, 32'h04030201, 4, 8'h93, 32'h03020104};
    vecs[5] = '{1'b0, 4'b0100, 32'h00550000, 1, 8'h02, 32'h00000055};

    z_valid    = 4'b0001;
    z_req_data = 32'h000000C5;
    z_last     = 4'b1111;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Single frame timing and inter-frame gap.
    push(0, 8'h5A, 1'b1);
    wait_grant("t1", 4'b0001, 50);
    chk("t1_grant_cycle_ready", int'(req_ready), 0);
    chk("t1_grant_cycle_start", int'(tx_start), 0);
    chk("t1_busy", int'(busy), 1);
    tick();
    chk("t1_req_ready_pulse", int'(req_ready), 1);
    chk("t1_start_early", int'(tx_start), 0);
    tick();
    chk("t1_req_ready_width", int'(req_ready), 0);
    chk("t1_start", int'(tx_start), 1);
    chk("t1_data", int'(tx_data), 'h5A);
    tick();
    chk("t1_start_width", int'(tx_start), 0);
    chk("t1_data_stable", int'(tx_data), 'h5A);
    push(0, 8'h11, 1'b1);
    wait_obs("t1", 2, 200);
    if (obs_idx.size() >= 2) begin
      chk("t1_second_data", int'(obs_data[1]), 'h11);
      chk("t1_gap_latency", last_start_cyc - ready_rise_cyc, GAP + 4);
    end
    wait_idle("t1");

    // Table-driven round-robin vectors; expected order follows from ptr history.
    for (int n = 0; n < 6; n++) begin
      v = vecs[n];
      if (v.rst_first) do_reset();
      obs_idx.delete();
      obs_data.delete();
      for (int i = 0; i < NREQ; i++) if (v.mask[i]) push(i, v.data[i*N +: N], 1'b1);
      wait_obs($sformatf("vec%0d", n), v.nexp, 500);
      for (int k = 0; k < v.nexp; k++) begin
        if (k < obs_idx.size()) begin
          chk($sformatf("vec%0d_frame%0d_req", n, k), obs_idx[k], int'(v.exp_idx[k*2 +: 2]));
          chk($sformatf("vec%0d_frame%0d_data", n, k), int'(obs_data[k]), int'(v.exp_data[k*8 +: 8]));
        end
      end
      $display("vector %0d: %0d frames observed", n, obs_idx.size());
      wait_idle($sformatf("vec%0d", n));
    end

    // Burst lock: req2 must wait for the whole req1 burst.
    do_reset();
    push(1, 8'h13, 1'b0);
    push(1, 8'h7D, 1'b0);
    push(1, 8'h65, 1'b1);
    push(2, 8'h99, 1'b1);
    wait_obs("t3", 4, 600);
    if (obs_idx.size() >= 4) begin
      chk("t3_f0_req", obs_idx[0], 1);
      chk("t3_f0_data", int'(obs_data[0]), 'h13);
      chk("t3_f1_req", obs_idx[1], 1);
      chk("t3_f1_data", int'(obs_data[1]), 'h7D);
      chk("t3_f2_req", obs_idx[2], 1);
      chk("t3_f2_data", int'(obs_data[2]), 'h65);
      chk("t3_f3_req", obs_idx[3], 2);
      chk("t3_f3_data", int'(obs_data[3]), 'h99);
    end
    wait_idle("t3");

    // Lock timeout: req1 leaves its burst open, req3 waits for the timeout.
    do_reset();
    push(1, 8'h2E, 1'b0);
    push(3, 8'h3C, 1'b1);
    busy_drop = 0;
    b = 0;
    while (grant != 4'b1000 && b < 400) begin
      tick();
      b++;
      if (obs_idx.size() >= 1 && !busy) busy_drop++;
    end
    chk("t4_req3_granted", int'(grant), 'h8);
    chk("t4_timeout_latency", grant_rise_cyc - ready_rise_cyc, GAP + LOCK_TMO + 2);
    chk("t4_busy_held", busy_drop, 0);
    wait_obs("t4", 2, 200);
    if (obs_idx.size() >= 2) begin
      chk("t4_f0_req", obs_idx[0], 1);
      chk("t4_f0_data", int'(obs_data[0]), 'h2E);
      chk("t4_f1_req", obs_idx[1], 3);
      chk("t4_f1_data", int'(obs_data[1]), 'h3C);
    end
    wait_idle("t4");

    // Reset while the frame is in flight.
    do_reset();
    push(2, 8'h42, 1'b1);
    b = 0;
    while (!(obs_idx.size() >= 1 && !tx_ready) && b < 200) begin
      tick();
      b++;
    end
    chk("t5_frame_started", int'(tx_ready), 0);
    tick();
    rst = 1'b1;
    flush();
    tick();
    chk("t5_rst_req_ready", int'(req_ready), 0);
    chk("t5_rst_grant", int'(grant), 0);
    chk("t5_rst_tx_start", int'(tx_start), 0);
    chk("t5_rst_tx_data", int'(tx_data), 0);
    chk("t5_rst_busy", int'(busy), 0);
    rst = 1'b0;
    obs_idx.delete();
    obs_data.delete();
    push(0, 8'hA0, 1'b1);
    push(2, 8'hA2, 1'b1);
    wait_obs("t5", 2, 300);
    if (obs_idx.size() >= 2) begin
      chk("t5_f0_req", obs_idx[0], 0);
      chk("t5_f0_data", int'(obs_data[0]), 'hA0);
      chk("t5_f1_req", obs_idx[1], 2);
      chk("t5_f1_data", int'(obs_data[1]), 'hA2);
    end
    wait_idle("t5");

    // UART not ready: nothing may be granted or started.
    hold = 1'b1;
    do_reset();
    push(2, 8'h66, 1'b1);
    viol = 0;
    repeat (20) begin
      tick();
      if (grant != '0 || tx_start || req_ready != '0) viol++;
    end
    chk("t6_no_activity", viol, 0);
    chk("t6_no_frames", obs_idx.size(), 0);
    hold = 1'b0;
    wait_obs("t6", 1, 100);
    if (obs_idx.size() >= 1) begin
      chk("t6_req", obs_idx[0], 2);
      chk("t6_data", int'(obs_data[0]), 'h66);
    end
    wait_idle("t6");

    // GAP=0 instance: frames back to back with only FSM latency between them.
    z_starts.delete();
    b = 0;
    while (z_starts.size() < 3 && b < 300) begin
      tick();
      b++;
    end
    chk("t6z_frames", (z_starts.size() >= 3) ? 3 : z_starts.size(), 3);
    if (z_starts.size() >= 3) begin
      chk("t6z_interval0", z_starts[1] - z_starts[0], FRAME + 5);
      chk("t6z_interval1", z_starts[2] - z_starts[1], FRAME + 5);
    end
    chk("t6z_data", int'(z_data), 'hC5);

    chk("grant_onehot", multi_grant, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
